// File: rtl/effect_noise_gate.sv
// effect_noise_gate
// Per-sample noise gate placed ahead of the chorus stage. A peak envelope
// follower feeds a five-state gate FSM (closed/attack/open/hold/release)
// that produces a 0..256 gain. The gain is applied to each sample with a
// registered multiply.
//
// Pipeline (one sample per i_valid, back-to-back allowed):
//   stage 1: latch sample, update envelope
//   stage 2: one FSM step (uses env including this sample, samples i_level
//            and i_enable), produces this sample's gain
//   stage 3: o_data = (x * gain) >>> 8
//
// Ports:
//   i_clk     sole clock
//   i_rst     synchronous active-high reset
//   i_valid   one-cycle strobe marking i_data valid
//   i_enable  1 = gate active, 0 = bypass (gain forced to 256)
//   i_level   threshold select, threshold = 32 << i_level
//   i_data    signed 16-bit input sample
//   o_data    gated sample, holds its value between strobes
//   o_valid   one-cycle strobe, three cycles after the matching i_valid
module effect_noise_gate #(
    parameter int unsigned DECAY_SHIFT  = 6,
    parameter int unsigned HOLD_SAMPLES = 3200,
    parameter int unsigned ATTACK_STEP  = 16,
    parameter int unsigned RELEASE_STEP = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic [2:0]         i_level,
    input  logic signed [15:0] i_data,
    output logic signed [15:0] o_data,
    output logic               o_valid
);

    localparam int unsigned    HCW        = (HOLD_SAMPLES < 2) ? 1 : $clog2(HOLD_SAMPLES + 1);
    localparam logic [HCW-1:0] HOLD_INIT  = HCW'(HOLD_SAMPLES);
    localparam logic [31:0]    ATT_STEP_W = 32'(ATTACK_STEP);
    localparam logic [31:0]    REL_STEP_W = 32'(RELEASE_STEP);
    localparam logic [8:0]     GAIN_FULL  = 9'd256;
    // Gain used on the first release sample after the hold expires.
    localparam logic [8:0]     REL_FROM_FULL = (RELEASE_STEP >= 256) ? 9'd0 : 9'(256 - RELEASE_STEP);
    // Gain used on the first attack sample out of CLOSED.
    localparam logic [8:0]     ATT_FIRST  = (ATTACK_STEP >= 256) ? 9'd256 : ATT_STEP_W[8:0];

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } gate_state_t;

    // Stage 1 registers
    logic               v1_q;
    logic signed [15:0] x1_q;
    logic [14:0]        env_q, env_d;
    // Stage 2 registers (FSM)
    gate_state_t        state_q, state_d;
    logic [8:0]         gain_q, gain_d;
    logic [HCW-1:0]     hold_q, hold_d;
    logic               v2_q;
    logic signed [15:0] x2_q;

    logic [14:0]        abs_s;
    logic [14:0]        env_decay_s;
    logic [14:0]        thr_s;
    logic               above_s;
    logic [31:0]        att_sum_s;
    logic [8:0]         att_gain_s;
    logic [8:0]         rel_gain_s;
    logic signed [25:0] prod_unused_s;
    logic signed [15:0] o_data_d;

    // Stage-1 envelope: peak capture, otherwise proportional decay plus one.
    always_comb begin
        abs_s       = 15'd0;
        env_decay_s = env_q - (env_q >> DECAY_SHIFT) - {14'd0, (env_q != 15'd0)};
        env_d       = env_q;
        if (i_data[15]) begin
            // -32768 has no positive twin; clamp its magnitude to 32767.
            if (i_data == 16'sh8000) begin
                abs_s = 15'h7FFF;
            end else begin
                abs_s = 15'((~i_data) + 16'sd1);
            end
        end else begin
            abs_s = i_data[14:0];
        end
        if (i_valid) begin
            if (abs_s > env_q) begin
                env_d = abs_s;
            end else begin
                env_d = env_decay_s;
            end
        end else begin
            env_d = env_q;
        end
    end

    // Stage-2 gain arithmetic: saturating attack/release steps.
    always_comb begin
        thr_s      = 15'd32 << i_level;
        above_s    = (env_q >= thr_s);
        att_sum_s  = 32'(gain_q) + ATT_STEP_W;
        att_gain_s = 9'd0;
        rel_gain_s = 9'd0;
        if (att_sum_s >= 32'd256) begin
            att_gain_s = GAIN_FULL;
        end else begin
            att_gain_s = att_sum_s[8:0];
        end
        if (32'(gain_q) <= REL_STEP_W) begin
            rel_gain_s = 9'd0;
        end else begin
            rel_gain_s = gain_q - REL_STEP_W[8:0];
        end
    end

    // Stage-2 gate FSM: one step per sample, nothing moves on idle cycles.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        if (v1_q) begin
            if (!i_enable) begin
                // Bypass parks the gate fully open so re-enable is click-free.
                state_d = ST_OPEN;
                gain_d  = GAIN_FULL;
                hold_d  = {HCW{1'b0}};
            end else begin
                case (state_q)
                    ST_CLOSED: begin
                        if (above_s) begin
                            state_d = ST_ATTACK;
                            gain_d  = ATT_FIRST;
                        end else begin
                            gain_d  = 9'd0;
                        end
                    end
                    ST_ATTACK: begin
                        gain_d = att_gain_s;
                        if (att_gain_s == GAIN_FULL) begin
                            state_d = ST_OPEN;
                        end else begin
                            state_d = ST_ATTACK;
                        end
                    end
                    ST_OPEN: begin
                        gain_d = GAIN_FULL;
                        if (!above_s) begin
                            state_d = ST_HOLD;
                            hold_d  = HOLD_INIT;
                        end else begin
                            state_d = ST_OPEN;
                        end
                    end
                    ST_HOLD: begin
                        if (above_s) begin
                            state_d = ST_OPEN;
                            gain_d  = GAIN_FULL;
                        end else if (hold_q == {HCW{1'b0}}) begin
                            state_d = ST_RELEASE;
                            gain_d  = REL_FROM_FULL;
                        end else begin
                            hold_d  = hold_q - HCW'(1'b1);
                            gain_d  = GAIN_FULL;
                        end
                    end
                    ST_RELEASE: begin
                        if (above_s) begin
                            state_d = ST_ATTACK;
                            gain_d  = att_gain_s;
                        end else begin
                            gain_d = rel_gain_s;
                            if (rel_gain_s == 9'd0) begin
                                state_d = ST_CLOSED;
                            end else begin
                                state_d = ST_RELEASE;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_CLOSED;
                        gain_d  = 9'd0;
                        hold_d  = {HCW{1'b0}};
                    end
                endcase
            end
        end else begin
            state_d = state_q;
            gain_d  = gain_q;
            hold_d  = hold_q;
        end
    end

    // Stage-3 multiply: gain is zero-extended so the product stays signed;
    // bits [23:8] are the arithmetic >>>8 result (floor rounding).
    always_comb begin
        prod_unused_s = x2_q * $signed({1'b0, gain_q});
        o_data_d      = prod_unused_s[23:8];
    end

    // Pipeline and FSM state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q    <= 1'b0;
            x1_q    <= 16'sd0;
            env_q   <= 15'd0;
            state_q <= ST_CLOSED;
            gain_q  <= 9'd0;
            hold_q  <= {HCW{1'b0}};
            v2_q    <= 1'b0;
            x2_q    <= 16'sd0;
            o_valid <= 1'b0;
            o_data  <= 16'sd0;
        end else begin
            v1_q    <= i_valid;
            if (i_valid) begin
                x1_q <= i_data;
            end
            env_q   <= env_d;
            state_q <= state_d;
            gain_q  <= gain_d;
            hold_q  <= hold_d;
            v2_q    <= v1_q;
            if (v1_q) begin
                x2_q <= x1_q;
            end
            o_valid <= v2_q;
            if (v2_q) begin
                o_data <= o_data_d;
            end
        end
    end

endmodule

// File: tb/tb_effect_noise_gate.sv
// Testbench for effect_noise_gate: hand-computed vector table, hand-written
// hold/release/retrigger/reset sequences, and randomized segments checked
// against a sample-level behavioural model of the gate.
module tb_effect_noise_gate;

    localparam int DS = 6;
    localparam int HS = 3200;
    localparam int AS = 16;
    localparam int RS = 1;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_enable = 1'b1;
    logic [2:0]         i_level = 3'd0;
    logic signed [15:0] i_data = 16'sd0;
    logic signed [15:0] o_data;
    logic               o_valid;

    effect_noise_gate #(
        .DECAY_SHIFT (DS),
        .HOLD_SAMPLES(HS),
        .ATTACK_STEP (AS),
        .RELEASE_STEP(RS)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_enable(i_enable),
        .i_level (i_level),
        .i_data  (i_data),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int last_out = 0;

    typedef struct {
        int    y;
        int    due;
        string name;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int data;
        bit en;
        int lvl;
        int exp;
    } vec_t;
    vec_t tbl[$];

    // ---------------- behavioural reference model ----------------
    typedef enum {P_CLOSED, P_ATTACK, P_OPEN, P_HOLD, P_RELEASE} phase_t;
    phase_t m_phase;
    int m_env, m_gain, m_hold;

    function automatic int env_next(int env, int x);
        int a;
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a > env) return a;
        return env - env / (1 << DS) - ((env != 0) ? 1 : 0);
    endfunction

    function automatic int floor_div256(int p);
        int q;
        q = p / 256;
        if (p < 0 && q * 256 != p) q = q - 1;
        return q;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_phase = P_CLOSED;
        m_env = 0;
        m_gain = 0;
        m_hold = 0;
    endtask

    task automatic model_step(input int x, input bit en, input int lvl, output int y);
        bit loud;
        m_env = env_next(m_env, x);
        loud = (m_env >= (32 << lvl));
        if (!en) begin
            m_phase = P_OPEN; m_gain = 256; m_hold = 0;
        end else begin
            case (m_phase)
                P_CLOSED: if (loud) begin m_phase = P_ATTACK; m_gain = imin(256, AS); end
                P_ATTACK: begin
                    m_gain = imin(256, m_gain + AS);
                    if (m_gain == 256) m_phase = P_OPEN;
                end
                P_OPEN: begin
                    m_gain = 256;
                    if (!loud) begin m_phase = P_HOLD; m_hold = HS; end
                end
                P_HOLD: begin
                    if (loud) m_phase = P_OPEN;
                    else if (m_hold == 0) begin m_phase = P_RELEASE; m_gain = imax(0, 256 - RS); end
                    else m_hold = m_hold - 1;
                end
                default: begin
                    if (loud) begin m_phase = P_ATTACK; m_gain = imin(256, m_gain + AS); end
                    else begin
                        m_gain = imax(0, m_gain - RS);
                        if (m_gain == 0) m_phase = P_CLOSED;
                    end
                end
            endcase
        end
        y = floor_div256(x * m_gain);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b0;
        end
    endtask

    // Drive one sample; use_exp selects a hand-computed expectation over the model.
    task automatic send(input int x, input bit en, input int lvl,
                        input bit use_exp, input int hexp, input string name);
        int y;
        exp_t e;
        // Control inputs are sampled one stage later, so let the previous sample clear first.
        if (en != i_enable || lvl != int'(i_level)) idle(1);
        @(posedge i_clk); #1;
        i_valid  = 1'b1;
        i_data   = 16'(x);
        i_enable = en;
        i_level  = 3'(lvl);
        model_step(x, en, lvl, y);
        e.y    = use_exp ? hexp : y;
        e.due  = cyc + 3;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_rst   = 1'b1;
        repeat (n) @(posedge i_clk);
        #1;
        n_vec += 2;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid got=%b want=0", o_valid);
        end
        if (o_data !== 16'sd0) begin
            n_err++;
            $display("FAIL reset_data got=%0d want=0", o_data);
        end
        exp_q.delete();
        model_reset();
        last_out = 0;
        i_rst = 1'b0;
    endtask

    task automatic drain();
        int i;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge i_clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout outstanding=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- output monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                if (o_valid === 1'b1) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL spurious_valid got o_data=%0d want no strobe", o_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(o_data) != e.y || cyc != e.due) begin
                            n_err++;
                            $display("FAIL %s got=%0d@%0d want=%0d@%0d", e.name, o_data, cyc, e.y, e.due);
                        end
                    end
                    last_out = int'(o_data);
                end else if (int'(o_data) != last_out || o_valid !== 1'b0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL hold_between_strobes got=%0d valid=%b want=%0d", o_data, o_valid, last_out);
                end
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #900000;
        $display("FAIL watchdog cycles=%0d limit=90000", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    function automatic void add(int d, bit en, int lvl, int x);
        vec_t v;
        v.data = d; v.en = en; v.lvl = lvl; v.exp = x;
        tbl.push_back(v);
    endfunction

    initial begin
        int n_above, env, guard, x, n, lvl;
        bit en;

        // Idle below threshold, attack ramp (with one negative sample), bypass extremes, re-enable.
        for (int i = 0; i < 4; i++) add(10, 1'b1, 0, 0);
        add(1000, 1'b1, 0, 62);  add(1000, 1'b1, 0, 125);
        add(1000, 1'b1, 0, 187); add(1000, 1'b1, 0, 250);
        add(-1000, 1'b1, 0, -313);
        add(1000, 1'b1, 0, 375); add(1000, 1'b1, 0, 437); add(1000, 1'b1, 0, 500);
        add(1000, 1'b1, 0, 562); add(1000, 1'b1, 0, 625); add(1000, 1'b1, 0, 687);
        add(1000, 1'b1, 0, 750); add(1000, 1'b1, 0, 812); add(1000, 1'b1, 0, 875);
        add(1000, 1'b1, 0, 937); add(1000, 1'b1, 0, 1000); add(1000, 1'b1, 0, 1000);
        add(-32768, 1'b0, 0, -32768); add(32767, 1'b0, 0, 32767); add(-1, 1'b0, 0, -1);
        add(20, 1'b1, 0, 20); add(-20, 1'b1, 0, -20);

        model_reset();
        do_reset(3);
        foreach (tbl[i]) send(tbl[i].data, tbl[i].en, tbl[i].lvl, 1'b1, tbl[i].exp, "table");
        drain();

        // Negative first attack sample floors toward minus infinity.
        do_reset(3);
        send(-1000, 1'b1, 0, 1'b1, -63, "neg_attack");
        drain();

        // Hold length and release start, with envelope crossing found by plain arithmetic.
        env = 0;
        for (int i = 0; i < 16; i++) env = env_next(env, 1000);
        n_above = 0;
        for (int i = 0; i < 1000; i++) begin
            env = env_next(env, 20);
            if (env < 32) break;
            n_above++;
        end
        do_reset(3);
        for (int i = 0; i < 16; i++) send(1000, 1'b1, 0, 1'b0, 0, "open_ramp");
        for (int i = 0; i < n_above + 1 + HS; i++) send(20, 1'b1, 0, 1'b1, 20, "hold_full_gain");
        send(20, 1'b1, 0, 1'b1, 19, "release_first");
        guard = 0;
        while (m_gain != 100 && guard < 400) begin
            send(20, 1'b1, 0, 1'b0, 0, "release_ramp");
            guard++;
        end
        n_vec++;
        if (guard >= 400) begin
            n_err++;
            $display("FAIL release_reach_100 steps=%0d want<400", guard);
        end
        send(2000, 1'b1, 0, 1'b1, 906, "retrigger");
        for (int i = 0; i < 10; i++) send(2000, 1'b1, 0, 1'b0, 0, "reattack");
        drain();

        // Reset with two samples in flight: neither may emerge.
        do_reset(3);
        send(1000, 1'b1, 0, 1'b0, 0, "dropped");
        send(1000, 1'b1, 0, 1'b0, 0, "dropped");
        do_reset(1);
        idle(6);
        drain();

        // Randomized segments: loud bursts then long quiet runs, varying level/enable.
        do_reset(2);
        for (int s = 0; s < 8; s++) begin
            lvl = $urandom_range(0, 7);
            en  = ($urandom_range(0, 3) != 0);
            n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) begin
                x = int'($urandom_range(0, 65535)) - 32768;
                send(x, en, lvl, 1'b0, 0, "rand_loud");
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
            end
            n = $urandom_range(0, 3600);
            for (int i = 0; i < n; i++) begin
                x = int'($urandom_range(0, 8)) - 4;
                send(x, en, lvl, 1'b0, 0, "rand_quiet");
                if ($urandom_range(0, 15) == 0) idle(1);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/effect_noise_gate.md
# effect_noise_gate

Per-sample noise gate at the head of the effects chain. It sits between the codec input sample stream and the chorus stage, and its `o_data`/`o_valid` drive the chorus `i_data`/`i_valid` directly. A peak envelope follower feeds a five-state gate FSM (closed/attack/open/hold/release). The FSM produces a 0..256 gain ramp that is applied to each sample by a registered multiply. No SRAM access.

## Interface
- `DECAY_SHIFT`, default 6: envelope decay per sample is `env>>DECAY_SHIFT` plus 1; legal range ≥1.
- `HOLD_SAMPLES`, default 3200: samples held open after the envelope drops below threshold (100 ms at 32 kHz); legal range ≥1.
- `ATTACK_STEP`, default 16: gain increment per sample in attack.
- `RELEASE_STEP`, default 1: gain decrement per sample in release.
- `i_clk`, in, 1: sole clock.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `i_valid`, in, 1: one-cycle strobe marking `i_data` valid; may assert on every cycle.
- `i_enable`, in, 1: 1 = gate active, 0 = bypass.
- `i_level`, in, 3: threshold select; threshold = `32 << i_level` (32..4096).
- `i_data`, in, 16 signed: input sample.
- `o_data`, out, 16 signed: gated sample; holds its value between strobes.
- `o_valid`, out, 1: one-cycle strobe, exactly one per accepted `i_valid`.

## Operation
- **Reset values:** `o_data`=0, `o_valid`=0, env=0, state=CLOSED, gain=0, hold_cnt=0, all pipeline valids 0.
- **Stage 1** (on `i_valid`):
  - Latch the sample.
  - abs = |x|; -32768 maps to 32767.
  - env_next = abs if abs > env, else env − (env>>DECAY_SHIFT) − (env≠0 ? 1 : 0).
  - env is 15-bit unsigned and never underflows.
- **Stage 2:** one FSM step per sample. Compare env (including the current sample) against thr = `32<<i_level`; `i_level` is sampled in this stage. The gain computed in this step is the gain applied to this sample.
  - CLOSED: env≥thr → ATTACK, gain=min(256,ATTACK_STEP). Otherwise gain stays 0.
  - ATTACK: gain=min(256,gain+ATTACK_STEP). Reaching 256 → OPEN. Env is ignored in this state.
  - OPEN: gain=256. env<thr → HOLD, hold_cnt=HOLD_SAMPLES.
  - HOLD: gain=256.
    - env≥thr → OPEN.
    - else if hold_cnt=0 → RELEASE, gain=max(0,256−RELEASE_STEP).
    - else hold_cnt−1.
  - RELEASE:
    - env≥thr → ATTACK, gain=min(256,gain+ATTACK_STEP).
    - else gain=max(0,gain−RELEASE_STEP); reaching 0 → CLOSED.
  - Net effect: HOLD_SAMPLES below-threshold samples after the one that entered HOLD pass at gain 256; the next one begins release.
- **Stage 3:**
  - `o_data` = (x × gain) >>> 8, where gain is 9-bit unsigned zero-extended and the product is 25-bit signed.
  - Arithmetic shift means floor rounding toward −∞.
  - gain=256 gives exactly x; gain=0 gives 0. No saturation is needed.
- **Bypass** (`i_enable`=0, sampled in stage 2):
  - The envelope keeps tracking.
  - FSM is forced to OPEN, gain=256, hold_cnt=0.
  - `o_data` = x with the same latency.
  - On re-enable, gating starts from OPEN with no click.

## Timing
- Fully pipelined, 3 registers deep. `i_valid` at cycle t gives `o_valid` at t+3, in order, with no gaps introduced.
- Back-to-back `i_valid` is supported. The stage-2 step for sample n uses env including sample n and FSM state after sample n−1.
- Non-valid cycles change no state: env, FSM, gain and hold_cnt advance only on sample strobes.
- `i_rst` wins over everything: asserting it mid-stream drops in-flight samples (no `o_valid` for them) and restores reset values on the next edge.
- A sample arriving on the cycle `i_rst` deasserts is accepted normally.
- `i_level` change mid-stream takes effect at the next stage-2 step; no glitch handling.

## Test plan
- **Reset/idle:** hold `i_rst` 3 cycles, then 10 samples of value 10 at `i_level`=0 → `o_valid` 3 cycles after each strobe, `o_data`=0 throughout (env 10 < 32, CLOSED).
- **Attack ramp:** after reset, 20 consecutive samples of 1000, `i_level`=0 → outputs 62, 125, 187, … (1000·16k>>>8), sample 16 onward exactly 1000. Repeat with −1000 → first output −63 (floor).
- **Hold/release:** open the gate with 1000, then feed 0s → exactly 3200 zero-input samples after env drops below 32 keep gain 256 (verify by probing gain, or by substituting ±20 inputs). Next sample gain 255, decreasing by 1; CLOSED after 256 release samples.
- **Retrigger:** during release at gain 100, inject 2000 → that sample gain 116, output (2000·116)>>>8 = 906, state ATTACK.
- **Bypass/extremes:** `i_enable`=0 with −32768, 32767, −1 back-to-back → identical outputs at t+3. Re-enable with zeros → gain 256, then hold begins. Assert `i_rst` with 2 samples in flight → those 2 produce no `o_valid` and `o_data`=0.
